// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller driving an aes_128 core over its start/done handshake.
// Optional block counter output is enabled by defining AES_CBC_BLKCNT_EN.
module aes_cbc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_decrypt,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         busy,
  output logic         err_timeout,
  output logic         core_start,
  output logic         core_encrypt,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_ciphertext
`ifdef AES_CBC_BLKCNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]   state;
  logic         key_valid;
  logic         mode;
  logic         armed;
  logic [15:0]  wait_cnt;
  logic [127:0] key;
  logic [127:0] chain;
  logic [127:0] saved_in;
  logic         in_fire;
  logic         done_ok;
  logic         tmo;

  assign s_ready      = (state == S_IDLE) & key_valid & ~cfg_load;
  assign in_fire      = s_valid & s_ready;
  assign core_start   = (state == S_ISSUE);
  assign m_valid      = (state == S_OUT);
  assign busy         = (state != S_IDLE);
  assign core_encrypt = ~mode;
  assign core_key     = key;

  // A done level still high from the previous op must drop once before it counts.
  assign done_ok = (state == S_WAIT) & armed & core_done;
  assign tmo     = (state == S_WAIT) & ~done_ok & (wait_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      key_valid      <= 1'b0;
      mode           <= 1'b0;
      armed          <= 1'b0;
      wait_cnt       <= '0;
      key            <= '0;
      chain          <= '0;
      saved_in       <= '0;
      core_plaintext <= '0;
      m_data         <= '0;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            key         <= cfg_key;
            chain       <= cfg_iv;
            mode        <= cfg_decrypt;
            key_valid   <= 1'b1;
            err_timeout <= 1'b0;
          end else if (in_fire) begin
            core_plaintext <= mode ? s_data : (s_data ^ chain);
            if (mode) saved_in <= s_data;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          armed    <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!core_done) armed <= 1'b1;
          wait_cnt <= wait_cnt + 16'd1;
          if (done_ok) begin
            m_data <= mode ? (core_ciphertext ^ chain) : core_ciphertext;
            chain  <= mode ? saved_in : core_ciphertext;
            state  <= S_OUT;
          end else if (tmo) begin
            // Abandon the block; chain keeps its pre-block value.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_OUT: begin
          if (m_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AES_CBC_BLKCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              blk_count <= '0;
    else if ((state == S_IDLE) && cfg_load) blk_count <= '0;
    else if (m_valid && m_ready)          blk_count <= blk_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Randomized + directed bench for aes_cbc_ctrl against a block-level CBC model,
// with a stub core (FIPS-197 vector plus a toy invertible cipher).
module tb_aes_cbc_ctrl;
  localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_F   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_F   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PXC_F  = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

  logic clk = 1'b0;
  logic rst, cfg_load, cfg_decrypt, s_valid, m_ready, core_done;
  logic [127:0] cfg_key, cfg_iv, s_data, core_ciphertext;
  logic s_ready, m_valid, busy, err_timeout, core_start, core_encrypt;
  logic [127:0] m_data, core_plaintext, core_key;
`ifdef AES_CBC_BLKCNT_EN
  logic [31:0] blk_count;
`endif

  always #5 clk = ~clk;

  aes_cbc_ctrl #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_decrypt(cfg_decrypt), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .err_timeout(err_timeout), .core_start(core_start), .core_encrypt(core_encrypt),
    .core_plaintext(core_plaintext), .core_key(core_key), .core_done(core_done),
    .core_ciphertext(core_ciphertext)
`ifdef AES_CBC_BLKCNT_EN
    , .blk_count(blk_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub cipher: real FIPS-197 pair for the published vector, toy rotate/xor otherwise.
  function automatic logic [127:0] core_fn(input logic enc, input logic [127:0] k, input logic [127:0] d);
    logic [127:0] t;
    if (k == K_FIPS && enc && d == PT_F) return CT_F;
    if (k == K_FIPS && !enc && d == CT_F) return PT_F;
    if (enc) return {d[114:0], d[127:115]} ^ k;
    t = d ^ k;
    return {t[12:0], t[127:13]};
  endfunction

  // ---------------- stub core ----------------
  logic hang = 1'b0;
  int   fixed_lat = 0;

  initial begin
    core_done = 1'b0;
    core_ciphertext = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        int s, l;
        logic [127:0] r;
        s = $urandom_range(0, 2);
        l = (fixed_lat != 0) ? fixed_lat : $urandom_range(2, 6);
        r = core_fn(core_encrypt, core_key, core_plaintext);
        repeat (s) begin
          @(negedge clk);
          core_ciphertext = rnd128();
        end
        core_done = 1'b0;
        while (hang) @(negedge clk);
        repeat (l) @(negedge clk);
        core_done = 1'b1;
        core_ciphertext = r;
      end
    end
  end

  // ---------------- block-level CBC model + compare ----------------
  logic m_kv, m_mode, pend_v, prev_err, in_acc, cfg_acc;
  logic [127:0] m_key, m_chain, pend_pt, pend_out, pend_chain;
  logic [31:0] m_blk;
  int n_start = 0;
  int n_mv = 0;

  initial begin
    m_kv = 0; m_mode = 0; pend_v = 0; prev_err = 0;
    m_key = '0; m_chain = '0; m_blk = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      m_kv = 0; m_mode = 0; pend_v = 0; prev_err = 0;
      m_key = '0; m_chain = '0; m_blk = '0;
    end else begin
      if (err_timeout && !prev_err) pend_v = 0;
      chkb("busy", busy, pend_v);
      chkb("s_ready", s_ready, m_kv && !pend_v && !cfg_load);
`ifdef AES_CBC_BLKCNT_EN
      chk("blk_count", {96'd0, blk_count}, {96'd0, m_blk});
`endif
      in_acc  = s_valid && m_kv && !pend_v && !cfg_load;
      cfg_acc = cfg_load && !pend_v;
      if (core_start) begin
        n_start++;
        chk("core_pt", core_plaintext, pend_pt);
        chk("core_key", core_key, m_key);
        chkb("core_enc", core_encrypt, !m_mode);
      end
      if (m_valid) begin
        n_mv++;
        chk("m_data", m_data, pend_out);
        if (m_ready) begin
          m_chain = pend_chain;
          pend_v = 0;
          m_blk = m_blk + 32'd1;
        end
      end
      if (cfg_acc) begin
        m_key = cfg_key; m_chain = cfg_iv; m_mode = cfg_decrypt; m_kv = 1; m_blk = '0;
      end else if (in_acc) begin
        pend_v = 1;
        if (m_mode) begin
          pend_pt = s_data;
          pend_out = core_fn(1'b0, m_key, s_data) ^ m_chain;
          pend_chain = s_data;
        end else begin
          pend_pt = s_data ^ m_chain;
          pend_out = core_fn(1'b1, m_key, pend_pt);
          pend_chain = pend_out;
        end
      end
      prev_err = err_timeout;
    end
  end

  // ---------------- directed / random stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] iv, input logic dec);
    cfg_key = k; cfg_iv = iv; cfg_decrypt = dec; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!(s_valid && s_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chkb("s_accept", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] pt, output logic [127:0] out);
    int t;
    t = 0;
    pt = '0;
    while (!m_valid && t < 100) begin
      @(negedge clk);
      if (core_start) pt = core_plaintext;
      t++;
    end
    chkb("m_valid_seen", m_valid, 1'b1);
    out = m_data;
    tick();
  endtask

  task automatic send(input logic [127:0] d, output logic [127:0] pt, output logic [127:0] out);
    s_valid = 1'b1; s_data = d; m_ready = 1'b1;
    wait_accept();
    wait_out(pt, out);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    chkb("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, out, d0, b;
    int ns, mv0, t;
    rst = 1; cfg_load = 0; cfg_decrypt = 0; s_valid = 0; m_ready = 1;
    cfg_key = '0; cfg_iv = '0; s_data = '0;
    repeat (3) tick();
    rst = 0;

    // reset state
    @(negedge clk);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_m_valid", m_valid, 1'b0);
    chkb("rst_core_start", core_start, 1'b0);
    chkb("rst_err", err_timeout, 1'b0);
    chkb("rst_core_enc", core_encrypt, 1'b1);
    chkb("rst_s_ready", s_ready, 1'b0);
    chk("rst_core_key", core_key, '0);
    chk("rst_core_pt", core_plaintext, '0);
    chk("rst_m_data", m_data, '0);
    tick();

    // FIPS-197 encrypt, IV 0
    load(K_FIPS, '0, 1'b0);
    ns = n_start;
    send(PT_F, pt, out);
    chk("t1_core_pt", pt, PT_F);
    chk("t1_m_data", out, CT_F);
    chkb("t1_one_start", (n_start - ns) == 1, 1'b1);

    // chained encrypt
    load(K_FIPS, PT_F, 1'b0);
    send('0, pt, out);
    chk("t2a_core_pt", pt, PT_F);
    chk("t2a_m_data", out, CT_F);
    send(CT_F, pt, out);
    chk("t2b_core_pt", pt, '0);

    // decrypt; second block proves chain became CT_F
    load(K_FIPS, PT_F, 1'b1);
    send(CT_F, pt, out);
    chk("t3a_m_data", out, '0);
    send(CT_F, pt, out);
    chk("t3b_core_pt", pt, CT_F);
    chk("t3b_m_data", out, PXC_F);

    // backpressure in OUT
    m_ready = 0; s_valid = 1; s_data = rnd128();
    wait_accept();
    t = 0;
    while (!m_valid && t < 100) begin tick(); t++; end
    d0 = m_data;
    repeat (10) begin
      @(negedge clk);
      chkb("bp_m_valid", m_valid, 1'b1);
      chk("bp_m_data", m_data, d0);
      chkb("bp_s_ready", s_ready, 1'b0);
      chkb("bp_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    m_ready = 1; s_valid = 1; s_data = rnd128();
    @(negedge clk);
    chkb("bp_xfer_valid", m_valid, 1'b1);
    @(negedge clk);
    chkb("bp_next_ready", s_ready, 1'b1);
    chkb("bp_next_mvalid", m_valid, 1'b0);
    @(posedge clk); #1;
    s_valid = 0;
    wait_idle();

    // cfg_load and s_valid in the same IDLE cycle
    b = rnd128(); d0 = rnd128();
    cfg_key = rnd128(); cfg_iv = d0; cfg_decrypt = 0; cfg_load = 1;
    s_valid = 1; s_data = b;
    @(negedge clk);
    chkb("cfgsv_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    cfg_load = 0;
    @(negedge clk);
    chkb("cfgsv_accept_next", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 0;
    @(negedge clk);
    chkb("cfgsv_start", core_start, 1'b1);
    chk("cfgsv_core_pt", core_plaintext, b ^ d0);
    wait_idle();

    // randomized traffic with ignored cfg_load while busy
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) load(rnd128(), rnd128(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
      s_valid = 1; s_data = rnd128();
      wait_accept();
      t = 0;
      while (busy && t < 300) begin
        m_ready = 1'($urandom_range(0, 1));
        cfg_load = ($urandom_range(0, 7) == 0);
        cfg_key = rnd128(); cfg_iv = rnd128(); cfg_decrypt = 1'($urandom_range(0, 1));
        tick();
        t++;
      end
      cfg_load = 0; m_ready = 1;
      chkb("rnd_done", busy, 1'b0);
    end

    // timeout with a core that never finishes
    hang = 1;
    s_valid = 1; s_data = rnd128();
    wait_accept();
    @(negedge clk);
    chkb("tmo_issue", core_start, 1'b1);
    mv0 = n_mv;
    repeat (255) @(negedge clk);
    chkb("tmo_err_before", err_timeout, 1'b0);
    chkb("tmo_busy_before", busy, 1'b1);
    @(negedge clk);
    chkb("tmo_err_rise", err_timeout, 1'b1);
    chkb("tmo_idle", busy, 1'b0);
    chkb("tmo_no_output", n_mv == mv0, 1'b1);
    @(posedge clk); #1;
    load(rnd128(), rnd128(), 1'b0);
    @(negedge clk);
    chkb("tmo_err_clear", err_timeout, 1'b0);
    hang = 0;
    repeat (12) tick();

    // reset during WAIT
    fixed_lat = 20;
    s_valid = 1; s_data = rnd128();
    wait_accept();
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    tick();
    rst = 0;
    mv0 = n_mv;
    @(negedge clk);
    chkb("rstw_m_valid", m_valid, 1'b0);
    chkb("rstw_busy", busy, 1'b0);
    chkb("rstw_s_ready", s_ready, 1'b0);
    repeat (30) @(negedge clk);
    chkb("rstw_no_late_output", n_mv == mv0, 1'b1);
    fixed_lat = 0;
    @(posedge clk); #1;
    load(K_FIPS, '0, 1'b0);
    send(PT_F, pt, out);
    chk("post_rst_m_data", out, CT_F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
- Initiator side of the AES core's start/done interface.
- Accepts 128-bit blocks on a valid/ready stream and applies CBC chaining (IV XOR on encrypt, previous-ciphertext XOR on decrypt).
- Issues one start pulse per block to the aes_128 core, waits for its done, and presents the chained result on an output valid/ready stream.
- Sits between the DMA/stream fabric and aes_128.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the block is abandoned; range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  load key/IV/mode; honoured only in IDLE.
- cfg_key  in  128  AES key.
- cfg_iv  in  128  initial chaining value.
- cfg_decrypt  in  1  1=CBC decrypt, 0=CBC encrypt.
- s_valid  in  1  input block valid.
- s_ready  out  1  input block accept.
- s_data  in  128  input block (plaintext or ciphertext).
- m_valid  out  1  output block valid.
- m_ready  in  1  output consumer ready.
- m_data  out  128  output block.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky; core failed to finish within TIMEOUT_CYCLES.
- core_start  out  1  one-cycle start pulse to aes_128.
- core_encrypt  out  1  =~mode_decrypt register.
- core_plaintext  out  128  core data input, registered.
- core_key  out  128  =key register.
- core_done  in  1  core completion, level.
- core_ciphertext  in  128  core data output.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; key_valid=0; key, chain, mode, saved_in, core_plaintext, m_data = 0.
  - m_valid, core_start, busy, err_timeout = 0.
  - core_encrypt=1.
  - Reset mid-operation discards the block in flight; no output is produced.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - s_ready = key_valid & ~cfg_load (combinational).
  - cfg_load: key<=cfg_key, chain<=cfg_iv, mode<=cfg_decrypt, key_valid<=1. If s_valid is high in the same cycle, cfg_load wins and the block is not taken.
  - s_valid&s_ready: encrypt mode loads core_plaintext<=s_data^chain. Decrypt mode loads core_plaintext<=s_data and saved_in<=s_data. Next state ISSUE.
- ISSUE:
  - core_start=1 for exactly this cycle.
  - Clears wait counter and armed flag; next state WAIT.
- WAIT:
  - armed<=1 on the first cycle core_done=0. Stale done held over from a previous op is ignored.
  - armed & core_done: encrypt mode loads m_data<=core_ciphertext and chain<=core_ciphertext. Decrypt mode loads m_data<=core_ciphertext^chain and chain<=saved_in. Next state OUT.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no accepted done: err_timeout<=1, chain unchanged, block dropped, next state IDLE.
- OUT:
  - m_valid=1; m_data stable until m_ready.
  - m_valid&m_ready: next state IDLE. The earliest next s_ready is the following cycle (no overlap).
- Ignored inputs:
  - cfg_load outside IDLE is ignored.
  - err_timeout clears only on rst or an accepted cfg_load.
- Minimum latency: s handshake to m_valid = 3 cycles plus core latency.
- All XORs are full 128-bit; no byte swapping. Bit 127 is the first byte's MSB, as in aes_128.

Optional Feature:
- Macro AES_CBC_BLKCNT_EN.
- Defined: adds output port blk_count [31:0].
  - Increments on each m_valid&m_ready and wraps from FFFFFFFF to 0.
  - Cleared by rst and by an accepted cfg_load.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Encrypt with key 000102030405060708090a0b0c0d0e0f, IV 0, cfg_decrypt=0, block 00112233445566778899aabbccddeeff:
  - core_plaintext = 00112233445566778899aabbccddeeff.
  - m_data = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - exactly one core_start pulse per block.
- Same key, IV 00112233445566778899aabbccddeeff, encrypt, blocks 0 then 69c4e0d86a7b0430d8cdb78070b4c55a:
  - block 1: core_plaintext=00112233..eeff, m_data=69c4e0d8..c55a.
  - block 2: core_plaintext=0.
- Decrypt with the same key, IV 00112233445566778899aabbccddeeff, block 69c4e0d86a7b0430d8cdb78070b4c55a:
  - m_data = 0.
  - chain register becomes 69c4e0d86a7b0430d8cdb78070b4c55a.
- Hold m_ready=0 for 10 cycles in OUT:
  - m_valid and m_data stay stable, s_ready=0, busy=1.
  - With m_ready=1, transfer occurs in that cycle; s_ready=1 the next cycle.
- Stub core that never asserts done, TIMEOUT_CYCLES=255:
  - err_timeout rises 255 cycles after entering WAIT.
  - state returns to IDLE, no m_valid.
  - cfg_load clears err_timeout.
- Reset scenarios:
  - rst asserted during WAIT: the next cycle shows m_valid=0, busy=0, s_ready=0 (key_valid cleared), and a late core_done produces no output.
  - cfg_load and s_valid in the same IDLE cycle: block not accepted; it is accepted the next cycle using the new key/IV.
